// File: rtl/aes_dec_iter.sv
// aes_dec_iter: iterative AES-128 inverse cipher for a fixed key.
// One shared inverse round per clock. Valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   ciphertext handshake; cipher_in sampled on accept edge
//   cipher_in[127:0]    ciphertext, bits [127:120] = state byte 0 (column-major)
//   out_valid/out_ready plaintext handshake
//   plain_out[127:0]    recovered plaintext, same byte order as cipher_in
//
// Optional feature: define AES_DEC_KEY_CACHE_EN to expand KEY to K10 once
// after reset (KINIT) and cache it, skipping per-block key expansion (KEXP).
module aes_dec_iter #(
   parameter logic [127:0] KEY = 128'h0123456789abcdef0123456789abcdef
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] cipher_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plain_out
);

   localparam int unsigned BW = 128;
   localparam int unsigned RW = 4;
   localparam logic [RW-1:0] LAST_RND = RW'(9);

`ifdef AES_DEC_KEY_CACHE_EN
   typedef enum logic [1:0] {KINIT, IDLE, ROUND, DONE} state_t;
   localparam state_t RST_STATE = KINIT;
`else
   typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;
   localparam state_t RST_STATE = IDLE;
`endif

   // ---------------- GF(2^8) helpers (poly 0x11b) ----------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0).
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   // Undo the affine map first, then invert.
   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   // ---------------- key schedule ----------------
   function automatic logic [7:0] rcon(input logic [RW-1:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [BW-1:0] key_fwd_step(input logic [BW-1:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;
      {w0, w1, w2, w3} = k;
      n0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h000000};
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // K_r -> K_(r-1); rc is Rcon[r].
   function automatic logic [BW-1:0] key_inv_step(input logic [BW-1:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, m0, m1, m2, m3;
      {w0, w1, w2, w3} = k;
      m3 = w3 ^ w2;
      m2 = w2 ^ w1;
      m1 = w1 ^ w0;
      m0 = w0 ^ sub_rot_word(m3) ^ {rc, 24'h000000};
      return {m0, m1, m2, m3};
   endfunction

   // ---------------- inverse round transforms ----------------
   // MSB position of state byte (row r, column c).
   function automatic int unsigned bpos(input int unsigned r, input int unsigned c);
      return 127 - 8 * (4 * c + r);
   endfunction

   function automatic logic [BW-1:0] inv_shift_rows(input logic [BW-1:0] s);
      logic [BW-1:0] o;
      o = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            o[bpos(r, c) -: 8] = s[bpos(r, (c + 4 - r) % 4) -: 8];
      return o;
   endfunction

   function automatic logic [BW-1:0] inv_sub_bytes(input logic [BW-1:0] s);
      logic [BW-1:0] o;
      o = '0;
      for (int unsigned i = 0; i < 16; i++)
         o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
      return o;
   endfunction

   function automatic logic [BW-1:0] inv_mix_columns(input logic [BW-1:0] s);
      logic [BW-1:0] o;
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      o = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            a[r]  = s[bpos(r, c) -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
         end
         o[bpos(0, c) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
         o[bpos(1, c) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
         o[bpos(2, c) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
         o[bpos(3, c) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      end
      return o;
   endfunction

   // ---------------- registers ----------------
   state_t          state, state_d;
   logic [BW-1:0]   st, st_d;
   logic [BW-1:0]   rk, rk_d;
   logic [RW-1:0]   rnd, rnd_d;
   logic            in_ready_d;
   logic            out_valid_d;
   logic [BW-1:0]   plain_d;
`ifdef AES_DEC_KEY_CACHE_EN
   logic [BW-1:0]   kc, kc_d;
`endif

   logic [BW-1:0]   k_fwd;
   logic [BW-1:0]   k_prev;
   logic [BW-1:0]   ark;
   logic [BW-1:0]   imc;

   // Next-state and datapath.
   always_comb begin
      state_d     = state;
      st_d        = st;
      rk_d        = rk;
      rnd_d       = rnd;
      in_ready_d  = in_ready;
      out_valid_d = out_valid;
      plain_d     = plain_out;
`ifdef AES_DEC_KEY_CACHE_EN
      kc_d        = kc;
      k_fwd       = key_fwd_step(kc, rcon(rnd + 4'd1));
`else
      k_fwd       = key_fwd_step(rk, rcon(rnd + 4'd1));
`endif
      // In ROUND, rk holds K_(rnd+1); step back to K_rnd for this round.
      k_prev      = key_inv_step(rk, rcon(rnd + 4'd1));
      ark         = inv_sub_bytes(inv_shift_rows(st)) ^ k_prev;
      imc         = inv_mix_columns(ark);

      case (state)
`ifdef AES_DEC_KEY_CACHE_EN
         KINIT: begin
            kc_d  = k_fwd;
            rnd_d = rnd + 4'd1;
            if (rnd == LAST_RND) begin
               rnd_d      = '0;
               in_ready_d = 1'b1;
               state_d    = IDLE;
            end
         end
`endif
         IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready) begin
               in_ready_d = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
               st_d    = cipher_in ^ kc;
               rk_d    = kc;
               rnd_d   = LAST_RND;
               state_d = ROUND;
`else
               st_d    = cipher_in;
               rk_d    = KEY;
               rnd_d   = '0;
               state_d = KEXP;
`endif
            end
         end
`ifndef AES_DEC_KEY_CACHE_EN
         KEXP: begin
            rk_d  = k_fwd;
            rnd_d = rnd + 4'd1;
            if (rnd == LAST_RND) begin
               st_d    = st ^ k_fwd;
               rnd_d   = LAST_RND;
               state_d = ROUND;
            end
         end
`endif
         ROUND: begin
            rk_d = k_prev;
            if (rnd == '0) begin
               st_d        = ark;
               plain_d     = ark;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               st_d  = imc;
               rnd_d = rnd - 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = RST_STATE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RST_STATE;
         st        <= '0;
         rk        <= '0;
         rnd       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         plain_out <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
         kc        <= KEY;
`endif
      end else begin
         state     <= state_d;
         st        <= st_d;
         rk        <= rk_d;
         rnd       <= rnd_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         plain_out <= plain_d;
`ifdef AES_DEC_KEY_CACHE_EN
         kc        <= kc_d;
`endif
      end
   end

endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed bench for aes_dec_iter: FIPS-197 C.1 / B vectors, latency,
// backpressure, back-to-back throughput and asynchronous mid-round reset.
module tb_aes_dec_iter;

`ifdef AES_DEC_KEY_CACHE_EN
   localparam int LAT      = 10;
   localparam int PERIOD   = 12;
   localparam int INIT_CYC = 10;
`else
   localparam int LAT      = 20;
   localparam int PERIOD   = 22;
   localparam int INIT_CYC = 1;
`endif

   localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_S  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] PT_S  = 128'h6bc1bee22e409f96e93d7e117393172a;

   logic         clk;
   logic         rst_n;
   logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [127:0] a_cipher, a_plain;
   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [127:0] b_cipher, b_plain;

   int n_assert;
   int n_fail;

   aes_dec_iter #(.KEY(KEY_A)) u_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .cipher_in (a_cipher),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .plain_out (a_plain)
   );

   aes_dec_iter #(.KEY(KEY_B)) u_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .cipher_in (b_cipher),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .plain_out (b_plain)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int acc_cyc [2];
      int out_cyc [2];
      logic [127:0] got [2];
      int nacc, nout, cyc;
      logic acc;

      n_assert = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_cipher = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b1; b_cipher = '0;

      // Reset values.
      tick(); tick();
      chk("rst_in_ready",  128'(a_in_ready),  128'(0));
      chk("rst_out_valid", 128'(a_out_valid), 128'(0));
      chk("rst_plain",     a_plain,           128'(0));
      rst_n = 1'b1;

      // in_ready rises INIT_CYC edges after release.
      for (int k = 1; k <= INIT_CYC; k++) begin
         tick();
         chk("init_in_ready", 128'(a_in_ready), 128'(k == INIT_CYC));
      end

      // C.1 vector, latency.
      a_cipher = CT_A;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      chk("acc_in_ready_low", 128'(a_in_ready), 128'(0));
      for (int k = 1; k <= LAT; k++) begin
         tick();
         chk("c1_latency", 128'(a_out_valid), 128'(k == LAT));
      end
      chk("c1_plain", a_plain, PT_A);

      // Backpressure in DONE with in_valid asserted.
      a_in_valid = 1'b1;
      a_cipher = 128'hdeadbeef_00000000_11111111_22222222;
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("bp_out_valid", 128'(a_out_valid), 128'(1));
         chk("bp_plain",     a_plain,           PT_A);
         chk("bp_in_ready",  128'(a_in_ready),  128'(0));
      end
      a_out_ready = 1'b1;
      tick();
      a_in_valid = 1'b0;
      chk("hs_out_valid", 128'(a_out_valid), 128'(0));
      chk("hs_in_ready",  128'(a_in_ready),  128'(1));
      chk("hs_plain_keep", a_plain,          PT_A);
      tick();
      chk("idle_in_ready", 128'(a_in_ready),  128'(1));
      chk("idle_out_valid", 128'(a_out_valid), 128'(0));

      // Back-to-back on key-B instance: Appendix B then SP800-38A block 1.
      b_cipher = CT_B;
      b_in_valid = 1'b1;
      nacc = 0; nout = 0; cyc = 0;
      acc_cyc[0] = 0; acc_cyc[1] = 0; out_cyc[0] = 0; out_cyc[1] = 0;
      got[0] = '0; got[1] = '0;
      while (nout < 2 && cyc < 200) begin
         acc = b_in_valid & b_in_ready;
         tick();
         cyc++;
         if (acc && nacc < 2) begin
            acc_cyc[nacc] = cyc;
            nacc++;
            if (nacc == 1) b_cipher = CT_S;
            else b_in_valid = 1'b0;
         end
         if (b_out_valid && nout < 2) begin
            out_cyc[nout] = cyc;
            got[nout] = b_plain;
            nout++;
         end
      end
      b_in_valid = 1'b0;
      chk("b2b_outputs_seen", 128'(nout), 128'(2));
      chk("b2b_plain0", got[0], PT_B);
      chk("b2b_plain1", got[1], PT_S);
      chk("b2b_latency0", 128'(out_cyc[0] - acc_cyc[0]), 128'(LAT));
      chk("b2b_period",   128'(acc_cyc[1] - acc_cyc[0]), 128'(PERIOD));
      chk("b2b_latency1", 128'(out_cyc[1] - acc_cyc[1]), 128'(LAT));

      // Asynchronous reset while rnd = 5.
      a_cipher = CT_A;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      repeat (LAT - 6) tick();
      chk("pre_rst_out_valid", 128'(a_out_valid), 128'(0));
      chk("pre_rst_plain_kept", a_plain, PT_A);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 128'(a_out_valid), 128'(0));
      chk("mid_rst_plain",     a_plain,           128'(0));
      chk("mid_rst_in_ready",  128'(a_in_ready),  128'(0));
      tick(); tick();
      rst_n = 1'b1;
      for (int k = 1; k <= INIT_CYC; k++) begin
         tick();
         chk("rerst_in_ready",  128'(a_in_ready),  128'(k == INIT_CYC));
         chk("rerst_out_valid", 128'(a_out_valid), 128'(0));
      end

      // Fresh C.1 block after reset.
      a_cipher = CT_A;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         chk("post_rst_latency", 128'(a_out_valid), 128'(k == LAT));
      end
      chk("post_rst_plain", a_plain, PT_A);
      tick();
      chk("post_rst_hs_in_ready", 128'(a_in_ready), 128'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
